// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave port: mode bit positions, FSM states
// and a helper that decodes a single bit of the MODE parameter.
package spi_slave_port_pkg;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic bit mode_bit(input int mode, input int pos);
    return ((mode >> pos) & 1) != 0;
  endfunction

endpackage

// File: rtl/spi_slave_port_if.sv
// Word-level application interface of the SPI slave port: tx holding-register
// handshake plus received-word and status strobes.
interface spi_slave_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             frame_abort;
  logic             busy;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
  );
endinterface

// File: rtl/spi_slave_port_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with single-cycle rise/fall
// pulses. The reset level is chosen per pin so that reset itself never
// fabricates an edge that the consumer would act on.
module spi_slave_port_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  // Metastability flops (p0, p1) followed by one history flop (p2) for edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      sync_p2 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave PHY: synchronises the SPI pins into clk, shifts WIDTH-bit words in
// both directions for any SPI mode, and offers a one-word tx holding register
// plus a received-word strobe to the application. MISO is only driven while
// the raw SSEL pin is low.
module spi_slave_port
  import spi_slave_port_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          MODE         = 0,
  parameter int          MSB_FIRST    = 1,
  parameter logic [31:0] IDLE_PATTERN = 32'hFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SSEL,
  input  logic            SCK,
  input  logic            MOSI,
  inout  wire             MISO,
  spi_slave_port_if.slave app
);

  localparam bit               CPOL   = mode_bit(MODE, CPOL_BIT);
  localparam bit               CPHA   = mode_bit(MODE, CPHA_BIT);
  localparam int               CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] IDLE_W = IDLE_PATTERN[WIDTH-1:0];

  // Bit currently presented on MISO for the chosen bit order
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the presented bit removed
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic ssel_rise, ssel_fall, ssel_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // SCK rests at CPOL after reset so no edge is seen on release.
  spi_slave_port_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst(rst), .d(SCK),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // SSEL rests low after reset: a pin already low cannot start a frame,
  // only a genuine later fall does; a rise seen in IDLE is harmless.
  spi_slave_port_sync_edge #(.RST_VAL(1'b0)) u_sync_ssel (
    .clk(clk), .rst(rst), .d(SSEL),
    .q(ssel_lvl_unused), .rise(ssel_rise), .fall(ssel_fall)
  );

  spi_slave_port_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(MOSI),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t           state;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] tx_sh;
  logic             tx_bit;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;
  logic             tx_underrun_r;
  logic             frame_abort_r;
  logic             busy_r;

  logic             sck_lead, sck_trail, sample_edge, shift_edge;
  logic             accept, tx_load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] rx_next;

  assign sck_lead    = CPOL ? sck_fall : sck_rise;
  assign sck_trail   = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead : sck_trail;

  assign accept    = app.tx_valid & ~hold_full;
  assign load_word = hold_full ? hold_data : IDLE_W;
  assign rx_next   = (MSB_FIRST != 0) ? {rx_sh[WIDTH-2:0], mosi_s}
                                      : {mosi_s, rx_sh[WIDTH-1:1]};

  // Tx shifter reload points: frame start, and word boundary. With CPHA=0 the
  // boundary is the shift edge that follows the last sample (bitcnt wrapped
  // to 0); with CPHA=1 it is the sample edge that completes the word.
  always_comb begin
    tx_load = 1'b0;
    if (state == ST_IDLE) begin
      tx_load = ssel_fall;
    end else if (!ssel_rise) begin
      if (CPHA) tx_load = sample_edge && (bitcnt == LAST);
      else      tx_load = shift_edge && (bitcnt == '0);
    end
  end

  // Frame FSM, bit counter, shifters, holding register and status strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bitcnt        <= '0;
      rx_sh         <= '0;
      tx_sh         <= '0;
      tx_bit        <= 1'b0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_abort_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      frame_abort_r <= 1'b0;
      tx_underrun_r <= tx_load & ~hold_full;

      // A word accepted in the same cycle as a load stays held; the load
      // takes whatever was held before.
      if (accept) begin
        hold_data <= app.tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end

      // CPHA=0 puts the first bit out at load time; CPHA=1 waits for the
      // leading edge to pop it.
      if (tx_load) begin
        if (CPHA) begin
          tx_sh <= load_word;
        end else begin
          tx_bit <= first_bit(load_word);
          tx_sh  <= drop_bit(load_word);
        end
      end else if (state == ST_ACTIVE && shift_edge && !ssel_rise) begin
        tx_bit <= first_bit(tx_sh);
        tx_sh  <= drop_bit(tx_sh);
      end

      case (state)
        ST_IDLE: begin
          if (ssel_fall) begin
            state  <= ST_ACTIVE;
            busy_r <= 1'b1;
            bitcnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (ssel_rise) begin
            state         <= ST_IDLE;
            busy_r        <= 1'b0;
            frame_abort_r <= (bitcnt != '0);
            bitcnt        <= '0;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            if (bitcnt == LAST) begin
              rx_data_r  <= rx_next;
              rx_valid_r <= 1'b1;
              bitcnt     <= '0;
            end else begin
              bitcnt <= bitcnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign MISO = SSEL ? 1'bz : tx_bit;

  assign app.tx_ready    = ~hold_full;
  assign app.rx_data     = rx_data_r;
  assign app.rx_valid    = rx_valid_r;
  assign app.tx_underrun = tx_underrun_r;
  assign app.frame_abort = frame_abort_r;
  assign app.busy        = busy_r;

endmodule
